jio_tty: RTL and testbench
==========================

Name: jio_tty

Overview:
- Output-port device hanging off the CPU IO bus. It consumes the IO control strobes (io_s, io_e, io_da, io_io) and the CPU bus.
- Latches the device address written by OUT ADDR. When selected, accepts OUT DATA bytes into a small FIFO.
- Drains the FIFO at a paced rate into a two-byte display register that feeds the seven-segment decoder.
- Answers IN DATA with a status byte, so programs can poll for space.

Parameters:
- DEV_ID, 0: device address this block answers to.
- DEPTH, 8: FIFO entries; must be a power of 2, range 2..16.
- DRAIN_DIV, 50000000: CLK cycles between drain ticks; minimum 2.

Ports:
- CLK  in  1  board clock; all logic on its rising edge.
- reset_n  in  1  synchronous active-low reset.
- bus_in  in  8  CPU bus value.
- io_s  in  1  IO set strobe, slow-clock domain.
- io_e  in  1  IO enable strobe, slow-clock domain.
- io_da  in  1  1 = address cycle, 0 = data cycle.
- io_io  in  1  1 = output (CPU->device), 0 = input.
- bus_out  out  8  status byte driven toward the CPU bus.
- bus_oe  out  1  bus_out valid; the top level muxes it onto the bus.
- dev_sel  out  8  last address latched by OUT ADDR.
- disp  out  16  {previous byte, newest byte} shown on the display.
- disp_stb  out  1  one-cycle pulse when disp updates.
- count  out  5  FIFO occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky flag: a byte was dropped.

Behaviour:
- Reset (reset_n=0 at a CLK edge): dev_sel=8'hFF, disp=0, disp_stb=0, count=0, empty=1, full=0, overflow=0, bus_oe=0, bus_out=0.
  - Also clears FIFO pointers, synchronizers, edge detectors and the drain counter.
  - Reset mid-transfer discards FIFO contents and any pending strobe edge.
- Synchronization: io_s, io_e, io_da, io_io and bus_in each pass through 2 flops.
  - Edge detect uses a third flop on io_s and io_e.
  - A CPU strobe therefore acts 3 CLK after it rises.
  - bus_in and direction bits are sampled from the synchronized copies in the same cycle the io_s rising edge is detected.
- OUT ADDR (io_s rise, io_da=1, io_io=1): dev_sel <= bus_in. Any device address is accepted.
- OUT DATA (io_s rise, io_da=0, io_io=1) while dev_sel==DEV_ID:
  - If not full (or a pop occurs in the same cycle), the byte is written at wr_ptr, wr_ptr increments, and count increments.
  - If full and no same-cycle pop, the byte is dropped and overflow <= 1.
  - While dev_sel != DEV_ID, OUT DATA is ignored.
- IN DATA (io_e high, io_da=0, io_io=0) while dev_sel==DEV_ID:
  - Set: bus_oe=1 and bus_out={overflow, full, empty, count[4:0]}, using registered values from the previous cycle.
  - bus_oe rises 3 CLK after io_e rises and falls 3 CLK after io_e falls.
  - On the synchronized io_e falling edge of such a read, overflow <= 0 (read-to-clear).
  - If a push also overflows in that cycle, overflow stays 1.
- Drain:
  - The tick counter counts 0..DRAIN_DIV-1 and wraps; a tick fires in the cycle it equals DRAIN_DIV-1.
  - On a tick with !empty: pop the byte at rd_ptr, rd_ptr increments, count decrements, disp <= {disp[7:0], byte}, disp_stb=1 for that one cycle.
  - On a tick with empty: nothing happens and disp_stb stays 0.
- Simultaneous push and pop: both are performed and count is unchanged.
  - When full, the pop frees a slot, so the push is accepted and overflow stays unchanged.
  - When empty, the pop is skipped and the push is accepted.
- Pointers are log2(DEPTH) bits and wrap naturally. full and empty derive from count, never from pointer compare alone.
- Flags full, empty and count update in the same cycle as the push or pop that changes them.

Test Plan:
- Reset mid-run (FIFO has 3 bytes) -> next cycle count=0, empty=1, disp=0, dev_sel=8'hFF; a drain tick produces no disp_stb.
- OUT ADDR 0x00, then OUT DATA 0x2A and 0x07 -> count=2; next two ticks give disp=0x002A then 0x2A07, each with a single-cycle disp_stb.
- OUT ADDR 0x05, then OUT DATA 0x11 -> ignored: count stays 0 and no disp change.
- DEPTH=8, DRAIN_DIV large: 9 OUT DATA writes -> count=8, full=1, overflow=1; IN DATA gives bus_out=0xC8 with bus_oe=1; after io_e falls, overflow=0.
- DRAIN_DIV=4, full FIFO, push timed on a tick cycle -> pop and push both succeed, count stays 8, overflow stays 0; data order is preserved across pointer wrap.
- IN DATA with dev_sel != DEV_ID -> bus_oe stays 0. IN DATA when empty, no overflow -> bus_out=0x20.

Source files
------------

// File: rtl/jio_tty.sv
// Output-only TTY device on the CPU IO bus: latches a device address, queues OUT DATA
// bytes in a small FIFO and drains them at a paced rate into a two-byte display register.
module jio_tty #(
    parameter logic [7:0] DEV_ID    = 8'h00,
    parameter int         DEPTH     = 8,
    parameter int         DRAIN_DIV = 50000000
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic [7:0]  bus_in,
    input  logic        io_s,
    input  logic        io_e,
    input  logic        io_da,
    input  logic        io_io,
    output logic [7:0]  bus_out,
    output logic        bus_oe,
    output logic [7:0]  dev_sel,
    output logic [15:0] disp,
    output logic        disp_stb,
    output logic [4:0]  count,
    output logic        full,
    output logic        empty,
    output logic        overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(DRAIN_DIV);

    typedef struct packed {
        logic       s;
        logic       e;
        logic       da;
        logic       io;
        logic [7:0] bus;
    } io_smp_t;

    io_smp_t                 sync1, sync2;
    logic                    s3, e3;
    logic [TW-1:0]           tick_cnt;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [DEPTH-1:0][7:0]   mem;

    logic s_rise, e_fall, selected;
    logic wr_addr, wr_data, rd_lvl;
    logic tick, pop, push, drop;

    // Bus value and direction bits travel with the strobes so they are sampled coherently.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            s3    <= 1'b0;
            e3    <= 1'b0;
        end else begin
            sync1 <= {io_s, io_e, io_da, io_io, bus_in};
            sync2 <= sync1;
            s3    <= sync2.s;
            e3    <= sync2.e;
        end
    end

    assign s_rise   = sync2.s & ~s3;
    assign e_fall   = ~sync2.e & e3;
    assign selected = (dev_sel == DEV_ID);
    assign wr_addr  = s_rise & sync2.da & sync2.io;
    assign wr_data  = s_rise & ~sync2.da & sync2.io & selected;
    assign rd_lvl   = sync2.e & ~sync2.da & ~sync2.io & selected;

    assign full     = (count == 5'(DEPTH));
    assign empty    = (count == 5'd0);

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign tick     = (tick_cnt == TW'(DRAIN_DIV - 1));
    assign pop      = tick & ~empty;
    assign push     = wr_data & (~full | pop);
    assign drop     = wr_data & full & ~pop;

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= sync2.bus;
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            dev_sel  <= 8'hFF;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            disp     <= '0;
            disp_stb <= 1'b0;
            bus_oe   <= 1'b0;
            bus_out  <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

            if (wr_addr)
                dev_sel <= sync2.bus;

            if (push)
                wr_ptr <= wr_ptr + 1'b1;

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                disp   <= {disp[7:0], mem[rd_ptr]};
            end
            disp_stb <= pop;

            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase

            // Read-to-clear happens when a status read ends; a fresh drop wins.
            if (drop)
                overflow <= 1'b1;
            else if (e_fall & bus_oe)
                overflow <= 1'b0;

            bus_oe  <= rd_lvl;
            bus_out <= rd_lvl ? {overflow, full, empty, count} : 8'h00;
        end
    end

endmodule

// File: tb/tb_jio_tty.sv
// Bench for jio_tty: two instances (slow and fast drain) share one stimulus stream and are
// compared every cycle against a queue-style reference model, plus directed checks.
module tb_jio_tty;

    localparam int DEPTH = 8;
    localparam int DIV0  = 200;
    localparam int DIV1  = 4;

    typedef struct packed {
        logic       s;
        logic       e;
        logic       da;
        logic       io;
        logic [7:0] bus;
    } smp_t;

    logic       CLK = 1'b0;
    logic       reset_n, io_s, io_e, io_da, io_io;
    logic [7:0] bus_in;

    logic [1:0][7:0]  bo_w, sel_w;
    logic [1:0][15:0] disp_w;
    logic [1:0][4:0]  cnt_w;
    logic [1:0]       oe_w, stb_w, full_w, empty_w, ovf_w;

    always #5 CLK = ~CLK;

    jio_tty #(.DEV_ID(8'h00), .DEPTH(DEPTH), .DRAIN_DIV(DIV0)) u_big (
        .CLK(CLK), .reset_n(reset_n), .bus_in(bus_in), .io_s(io_s), .io_e(io_e),
        .io_da(io_da), .io_io(io_io), .bus_out(bo_w[0]), .bus_oe(oe_w[0]),
        .dev_sel(sel_w[0]), .disp(disp_w[0]), .disp_stb(stb_w[0]), .count(cnt_w[0]),
        .full(full_w[0]), .empty(empty_w[0]), .overflow(ovf_w[0])
    );

    jio_tty #(.DEV_ID(8'h00), .DEPTH(DEPTH), .DRAIN_DIV(DIV1)) u_small (
        .CLK(CLK), .reset_n(reset_n), .bus_in(bus_in), .io_s(io_s), .io_e(io_e),
        .io_da(io_da), .io_io(io_io), .bus_out(bo_w[1]), .bus_oe(oe_w[1]),
        .dev_sel(sel_w[1]), .disp(disp_w[1]), .disp_stb(stb_w[1]), .count(cnt_w[1]),
        .full(full_w[1]), .empty(empty_w[1]), .overflow(ovf_w[1])
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: FIFO kept as a shift-down array, index 0 is the oldest byte.
    smp_t        m_smp[3];
    int          m_tc[2];
    int          m_cnt[2];
    logic [7:0]  m_fifo[2][DEPTH];
    logic        m_ovf[2], m_stb[2], m_oe[2];
    logic [7:0]  m_bo[2];
    logic [15:0] m_disp[2];
    logic [7:0]  m_sel;

    function automatic int div_of(input int i);
        return (i == 0) ? DIV0 : DIV1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        smp_t       cur, prv;
        logic       rise, efall, hit, tick, dropped, rd;
        logic [7:0] st;
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) m_smp[k] = '0;
            m_sel = 8'hFF;
            for (int i = 0; i < 2; i++) begin
                m_tc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 1'b0; m_stb[i] = 1'b0;
                m_oe[i] = 1'b0; m_bo[i] = 8'h00; m_disp[i] = 16'h0000;
            end
        end else begin
            cur   = m_smp[1];
            prv   = m_smp[2];
            rise  = cur.s && !prv.s;
            efall = !cur.e && prv.e;
            hit   = (m_sel == 8'h00);
            for (int i = 0; i < 2; i++) begin
                st      = {m_ovf[i], (m_cnt[i] == DEPTH), (m_cnt[i] == 0), 5'(m_cnt[i])};
                tick    = (m_tc[i] == div_of(i) - 1);
                m_stb[i] = tick && (m_cnt[i] > 0);
                if (m_stb[i]) begin
                    m_disp[i] = {m_disp[i][7:0], m_fifo[i][0]};
                    for (int k = 0; k < DEPTH - 1; k++) m_fifo[i][k] = m_fifo[i][k+1];
                    m_cnt[i]--;
                end
                dropped = 1'b0;
                if (rise && !cur.da && cur.io && hit) begin
                    if (m_cnt[i] < DEPTH) begin
                        m_fifo[i][m_cnt[i]] = cur.bus;
                        m_cnt[i]++;
                    end else begin
                        m_ovf[i] = 1'b1;
                        dropped  = 1'b1;
                    end
                end
                if (efall && m_oe[i] && !dropped) m_ovf[i] = 1'b0;
                rd      = cur.e && !cur.da && !cur.io && hit;
                m_bo[i] = rd ? st : 8'h00;
                m_oe[i] = rd;
                m_tc[i] = tick ? 0 : m_tc[i] + 1;
            end
            if (rise && cur.da && cur.io) m_sel = cur.bus;
            m_smp[2] = m_smp[1];
            m_smp[1] = m_smp[0];
            m_smp[0] = {io_s, io_e, io_da, io_io, bus_in};
        end
    endtask

    // Advance one clock: model steps on the rising edge, outputs are compared on the falling edge.
    task automatic cyc();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dev_sel%0d", i), 32'(sel_w[i]), 32'(m_sel));
            chk($sformatf("count%0d", i), 32'(cnt_w[i]), 32'(m_cnt[i]));
            chk($sformatf("full%0d", i), 32'(full_w[i]), 32'(m_cnt[i] == DEPTH));
            chk($sformatf("empty%0d", i), 32'(empty_w[i]), 32'(m_cnt[i] == 0));
            chk($sformatf("overflow%0d", i), 32'(ovf_w[i]), 32'(m_ovf[i]));
            chk($sformatf("disp%0d", i), 32'(disp_w[i]), 32'(m_disp[i]));
            chk($sformatf("disp_stb%0d", i), 32'(stb_w[i]), 32'(m_stb[i]));
            chk($sformatf("bus_oe%0d", i), 32'(oe_w[i]), 32'(m_oe[i]));
            chk($sformatf("bus_out%0d", i), 32'(bo_w[i]), 32'(m_bo[i]));
        end
    endtask

    task automatic out_op(input logic da, input logic [7:0] b);
        bus_in = b; io_da = da; io_io = 1'b1; io_s = 1'b1;
        cyc();
        io_s = 1'b0;
        cyc();
    endtask

    task automatic in_op(input int hold, output int seen, output logic [7:0] last_bo);
        seen = 0; last_bo = 8'h00;
        io_da = 1'b0; io_io = 1'b0; io_e = 1'b1;
        repeat (hold) begin
            cyc();
            if (oe_w[0] === 1'b1) begin
                seen++;
                last_bo = bo_w[0];
            end
        end
        io_e = 1'b0;
    endtask

    task automatic rst_pulse();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic wait_stb(input int i, input int lim);
        int n = 0;
        while (stb_w[i] !== 1'b1 && n < lim) begin
            cyc();
            n++;
        end
        chk("stb_timeout", 32'(n < lim), 32'd1);
    endtask

    initial begin
        int         seen, n;
        logic [7:0] bo;

        reset_n = 1'b0; io_s = 1'b0; io_e = 1'b0; io_da = 1'b0; io_io = 1'b0; bus_in = 8'h00;
        repeat (3) cyc();
        for (int i = 0; i < 2; i++) begin
            chk("rst_dev_sel", 32'(sel_w[i]), 32'h0FF);
            chk("rst_disp", 32'(disp_w[i]), 32'h0);
            chk("rst_count", 32'(cnt_w[i]), 32'h0);
            chk("rst_empty", 32'(empty_w[i]), 32'h1);
            chk("rst_full", 32'(full_w[i]), 32'h0);
            chk("rst_ovf", 32'(ovf_w[i]), 32'h0);
            chk("rst_oe", 32'(oe_w[i]), 32'h0);
            chk("rst_bus_out", 32'(bo_w[i]), 32'h0);
        end
        reset_n = 1'b1;

        // Two bytes, then watch them shift through the display on the slow instance.
        out_op(1'b1, 8'h00);
        out_op(1'b0, 8'h2A);
        out_op(1'b0, 8'h07);
        repeat (3) cyc();
        chk("two_count", 32'(cnt_w[0]), 32'd2);
        wait_stb(0, 450);
        chk("disp_first", 32'(disp_w[0]), 32'h002A);
        cyc();
        chk("stb_single", 32'(stb_w[0]), 32'd0);
        wait_stb(0, 450);
        chk("disp_second", 32'(disp_w[0]), 32'h2A07);

        // Writes to another device address are ignored.
        out_op(1'b1, 8'h05);
        out_op(1'b0, 8'h11);
        seen = 0;
        repeat (250) begin
            cyc();
            if (stb_w[0] === 1'b1) seen++;
        end
        chk("other_dev_cnt", 32'(cnt_w[0]), 32'd0);
        chk("other_dev_stb", 32'(seen), 32'd0);
        chk("other_dev_disp", 32'(disp_w[0]), 32'h2A07);

        in_op(8, seen, bo);
        chk("unsel_read_oe", 32'(seen), 32'd0);
        repeat (3) cyc();

        // Status read while empty, including bus_oe rise/fall latency.
        out_op(1'b1, 8'h00);
        in_op(8, seen, bo);
        chk("empty_read_oe_cycles", 32'(seen), 32'd6);
        chk("empty_read_status", 32'(bo), 32'h20);
        cyc(); cyc();
        chk("oe_hold", 32'(oe_w[0]), 32'd1);
        cyc();
        chk("oe_fall", 32'(oe_w[0]), 32'd0);

        // Reset with bytes queued throws them away.
        rst_pulse();
        out_op(1'b1, 8'h00);
        out_op(1'b0, 8'h31);
        out_op(1'b0, 8'h32);
        out_op(1'b0, 8'h33);
        repeat (3) cyc();
        chk("mid_count", 32'(cnt_w[0]), 32'd3);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("mid_rst_count", 32'(cnt_w[0]), 32'd0);
        chk("mid_rst_empty", 32'(empty_w[0]), 32'd1);
        chk("mid_rst_disp", 32'(disp_w[0]), 32'h0);
        chk("mid_rst_sel", 32'(sel_w[0]), 32'h0FF);
        seen = 0;
        repeat (210) begin
            cyc();
            if (stb_w[0] === 1'b1) seen++;
        end
        chk("mid_rst_no_stb", 32'(seen), 32'd0);

        // Nine writes into eight slots: overflow, status 0xC8, read-to-clear.
        rst_pulse();
        out_op(1'b1, 8'h00);
        for (int k = 0; k < 9; k++) out_op(1'b0, 8'(8'h40 + k));
        repeat (3) cyc();
        chk("ovf_count", 32'(cnt_w[0]), 32'd8);
        chk("ovf_full", 32'(full_w[0]), 32'd1);
        chk("ovf_flag", 32'(ovf_w[0]), 32'd1);
        in_op(8, seen, bo);
        chk("ovf_read_oe", 32'(seen), 32'd6);
        chk("ovf_read_status", 32'(bo), 32'hC8);
        repeat (4) cyc();
        chk("ovf_cleared", 32'(ovf_w[0]), 32'd0);

        // Fast drain: pushes alternate on/off tick; the push landing on a tick while full is kept.
        rst_pulse();
        out_op(1'b1, 8'h00);
        n = 0;
        while (m_tc[1] != 1 && n < 8) begin
            cyc();
            n++;
        end
        chk("align_timeout", 32'(n < 8), 32'd1);
        for (int k = 0; k < 15; k++) out_op(1'b0, 8'(8'hA0 + k));
        cyc();
        chk("tick_push_count", 32'(cnt_w[1]), 32'd8);
        chk("tick_push_stb", 32'(stb_w[1]), 32'd1);
        chk("tick_push_ovf", 32'(ovf_w[1]), 32'd0);
        n = 0;
        while (cnt_w[1] !== 5'd0 && n < 100) begin
            cyc();
            n++;
        end
        chk("drain_timeout", 32'(n < 100), 32'd1);
        cyc();
        chk("wrap_order", 32'(disp_w[1]), 32'hADAE);
        chk("wrap_ovf", 32'(ovf_w[1]), 32'd0);

        // Random traffic against the model.
        rst_pulse();
        repeat (300) begin
            case ($urandom_range(0, 9))
                0: out_op(1'b1, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
                1, 2, 3, 4, 5: out_op(1'b0, 8'($urandom));
                6: in_op($urandom_range(1, 6), seen, bo);
                7: repeat ($urandom_range(0, 10)) cyc();
                8: if ($urandom_range(0, 9) == 0) rst_pulse(); else cyc();
                default: repeat ($urandom_range(1, 3)) cyc();
            endcase
        end
        repeat (8) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
